// File: rtl/ins_mem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package ins_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DATA_WIDTH = 32;
    localparam int BYTES      = DATA_WIDTH / 8;

    // A single-byte word still needs a 1-bit lane counter to stay a legal vector.
    function automatic int lane_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    localparam int LANE_W = lane_width(BYTES);

endpackage

// File: rtl/ins_word_packer.sv
// Packs accepted bytes little-endian into one word; lane 0 is the first byte of a word.
module ins_word_packer
    import ins_mem_loader_pkg::*;
#(
    parameter int NB = BYTES
) (
    input  logic            clk,
    input  logic            RST,
    input  logic [7:0]      data_byte,
    input  logic            accept,
    input  logic            clear,
    output logic [NB*8-1:0] word,
    output logic            word_full
);

    localparam int LW = lane_width(NB);

    logic [NB*8-1:0] lanes;
    logic [LW-1:0]   lane;

    // The merged view lets the consumer capture the complete word on the final byte's edge.
    always_comb begin
        word = lanes;
        if (accept) begin
            word[int'(lane)*8 +: 8] = data_byte;
        end
    end

    assign word_full = accept && (lane == LW'(NB - 1));

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            lanes <= '0;
            lane  <= '0;
        end else if (clear) begin
            lanes <= '0;
            lane  <= '0;
        end else if (accept) begin
            lanes <= word;
            lane  <= word_full ? '0 : lane + LW'(1);
        end
    end

endmodule

// File: rtl/ins_mem_loader.sv
// Boot loader: streams bytes into instruction memory and releases the CPU once the image is written.
module ins_mem_loader
    import ins_mem_loader_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int Depth     = 100,
    parameter int CntWidth  = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 start,
    input  logic [CntWidth-1:0]  word_count,
    input  logic [7:0]           byte_data,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [DataWidth-1:0] WRData,
    output logic [DataWidth-1:0] Addres,
    output logic                 WREnable,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 cpu_hold,
    output state_t               dbg_state
);

    localparam int NB = DataWidth / 8;
    localparam logic [CntWidth-1:0] DEPTH_C = CntWidth'(Depth);

    state_t                state;
    logic [CntWidth-1:0]   rem;
    logic                  accept;
    logic                  clear;
    logic [DataWidth-1:0]  word;
    logic                  word_full;

    // Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both high;
    // the sender holds byte_data stable while byte_valid is high and byte_ready is low.
    assign accept    = byte_valid && byte_ready;
    assign clear     = (state == ST_IDLE);
    assign dbg_state = state;

    ins_word_packer #(.NB(NB)) u_packer (
        .clk       (clk),
        .RST       (RST),
        .data_byte (byte_data),
        .accept    (accept),
        .clear     (clear),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            rem        <= '0;
            byte_ready <= 1'b0;
            WRData     <= '0;
            Addres     <= '0;
            WREnable   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            done     <= 1'b0;
            WREnable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        rem   <= word_count;
                        if (word_count == '0) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (word_count > DEPTH_C) begin
                            error <= 1'b1;
                        end else begin
                            Addres     <= '0;
                            cpu_hold   <= 1'b1;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            state      <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (word_full) begin
                        byte_ready <= 1'b0;
                        WREnable   <= 1'b1;
                        WRData     <= word;
                        state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    rem <= rem - CntWidth'(1);
                    if (rem == CntWidth'(1)) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        Addres     <= Addres + DataWidth'(1);
                        byte_ready <= 1'b1;
                        state      <= ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
